// File: rtl/shift_sequencer.sv
// Command sequencer for the 4-bit shift register datapath: turns load/clear/shift/rotate
// commands into per-clock select, serial and parallel-load drive, then pulses done.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic             fill,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] q_in,
  output logic [1:0]       sel,
  output logic             ser_lsb,
  output logic             ser_msb,
  output logic [WIDTH-1:0] load_val,
  output logic             ready,
  output logic             done
);

  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       op_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic             fill_reg;
  logic [WIDTH-1:0] data_reg;
  logic             accept;
  logic             is_step_op;

  assign accept     = (state_reg == IDLE) && start;
  assign is_step_op = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      remaining_reg <= '0;
      fill_reg      <= 1'b0;
      data_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg        <= op;
        remaining_reg <= count;
        fill_reg      <= fill;
        data_reg      <= data_in;
      end else if (state_reg == SHIFT) begin
        remaining_reg <= remaining_reg - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (op == OP_LOAD || op == OP_CLEAR)      state_next = LOAD;
          else if (is_step_op && count != '0)       state_next = SHIFT;
          else                                      state_next = DONE;
        end
      end
      LOAD:    state_next = DONE;
      SHIFT:   if (remaining_reg == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Rotate serial bits come straight from the readback so each step sees the current value.
  always_comb begin
    sel      = 2'b00;
    ser_lsb  = 1'b0;
    ser_msb  = 1'b0;
    load_val = '0;
    ready    = 1'b0;
    done     = 1'b0;
    case (state_reg)
      IDLE: ready = 1'b1;
      LOAD: begin
        sel      = 2'b11;
        load_val = (op_reg == OP_CLEAR) ? '0 : data_reg;
      end
      SHIFT: begin
        case (op_reg)
          OP_SHL: begin sel = 2'b01; ser_lsb = fill_reg;       end
          OP_ROL: begin sel = 2'b01; ser_lsb = q_in[WIDTH-1];  end
          OP_SHR: begin sel = 2'b10; ser_msb = fill_reg;       end
          OP_ROR: begin sel = 2'b10; ser_msb = q_in[0];        end
          default: sel = 2'b00;
        endcase
      end
      DONE:    done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench: commands push expected per-cycle drive into a queue, a monitor
// pops and checks whenever the sequencer drives the datapath or pulses done.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [2:0] count = 3'b000;
  logic       fill = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic [3:0] q = 4'h0;
  logic [1:0] sel;
  logic       ser_lsb, ser_msb, ready, done;
  logic [3:0] load_val;

  int cyc = 0;
  int total_cnt = 0;
  int pass_cnt = 0;

  typedef struct {
    int         cyc;
    logic       dn;
    logic [1:0] sel;
    logic       lsb;
    logic       msb;
    logic [3:0] lv;
    logic [3:0] q;
  } rec_t;
  rec_t sb[$];

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .count(count), .fill(fill),
    .data_in(data_in), .q_in(q), .sel(sel), .ser_lsb(ser_lsb), .ser_msb(ser_msb),
    .load_val(load_val), .ready(ready), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // 4-bit datapath register driven by the sequencer; it has no reset of its own.
  always @(posedge clk) begin
    case (sel)
      2'b01:   q <= {q[2:0], ser_lsb};
      2'b10:   q <= {ser_msb, q[3:1]};
      2'b11:   q <= load_val;
      default: q <= q;
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n && (sel != 2'b00 || done)) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got sel=%b done=%b expected nothing (cycle %0d)", sel, done, cyc);
      end else begin
        rec_t r;
        r = sb.pop_front();
        $display("txn cyc=%0d sel=%b lsb=%b msb=%b lv=%h q=%h done=%b", cyc, sel, ser_lsb, ser_msb, load_val, q, done);
        chk("cycle", cyc, r.cyc);
        chk("done", int'(done), int'(r.dn));
        chk("sel", int'(sel), int'(r.sel));
        chk("ser_lsb", int'(ser_lsb), int'(r.lsb));
        chk("ser_msb", int'(ser_msb), int'(r.msb));
        chk("load_val", int'(load_val), int'(r.lv));
        chk("datapath", int'(q), int'(r.q));
        chk("ready_busy", int'(ready), 0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      total_cnt++;
      $display("FAIL ready_timeout: got ready=0 expected 1");
    end
  endtask

  // qv: hex digit i (from the left) is the datapath before step i; digit nsteps is the final value.
  // sv: bit 7-i is the serial bit expected on step i.
  task automatic issue(input logic [2:0] o, input logic [2:0] c, input logic f, input logic [3:0] d,
                       input int nsteps, input logic [1:0] es, input logic [3:0] elv,
                       input logic [7:0] sv, input logic [35:0] qv);
    int k;
    rec_t r;
    wait_ready();
    op = o; count = c; fill = f; data_in = d; start = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < nsteps; i++) begin
      r.cyc = k + i; r.dn = 1'b0; r.sel = es;
      r.lsb = (es == 2'b01) ? sv[7-i] : 1'b0;
      r.msb = (es == 2'b10) ? sv[7-i] : 1'b0;
      r.lv  = elv;
      r.q   = qv[35-4*i -: 4];
      sb.push_back(r);
    end
    r.cyc = k + nsteps; r.dn = 1'b1; r.sel = 2'b00; r.lsb = 1'b0; r.msb = 1'b0; r.lv = 4'h0;
    r.q = qv[35-4*nsteps -: 4];
    sb.push_back(r);
    @(posedge clk); #1;
    start = 1'b0; op = 3'b001; count = 3'b111; fill = ~f; data_in = ~d;
  endtask

  initial begin
    int k;
    rec_t r;
    #2;
    chk("reset_ready", int'(ready), 1);
    chk("reset_sel", int'(sel), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_load_val", int'(load_val), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    issue(3'b001, 3'd0, 1'b0, 4'hB, 1, 2'b11, 4'hB, 8'h00, 36'h0B0000000); // LOAD 1011
    issue(3'b010, 3'd2, 1'b1, 4'h0, 2, 2'b01, 4'h0, 8'b11000000, 36'hB7F000000); // SHL 2 fill 1
    issue(3'b001, 3'd0, 1'b0, 4'hB, 1, 2'b11, 4'hB, 8'h00, 36'hFB0000000);
    issue(3'b101, 3'd3, 1'b0, 4'h0, 3, 2'b10, 4'h0, 8'b11000000, 36'hBDE700000); // ROR 3
    issue(3'b100, 3'd1, 1'b1, 4'h0, 1, 2'b01, 4'h0, 8'b00000000, 36'h7E0000000); // ROL 1
    issue(3'b011, 3'd0, 1'b1, 4'h5, 0, 2'b10, 4'h0, 8'h00, 36'hE00000000);       // SHR count 0
    issue(3'b111, 3'd4, 1'b1, 4'h5, 0, 2'b00, 4'h0, 8'h00, 36'hE00000000);       // reserved op

    // start held high on NOP: accepted again in the IDLE cycle after DONE
    wait_ready();
    op = 3'b000; count = 3'd3; start = 1'b1;
    k = cyc + 1;
    r.dn = 1'b1; r.sel = 2'b00; r.lsb = 1'b0; r.msb = 1'b0; r.lv = 4'h0; r.q = 4'hE;
    r.cyc = k;     sb.push_back(r);
    r.cyc = k + 2; sb.push_back(r);
    repeat (3) @(posedge clk);
    #1 start = 1'b0;

    // SHR 3 fill 0 with a LOAD request during SHIFT that must be ignored
    issue(3'b011, 3'd3, 1'b0, 4'h0, 3, 2'b10, 4'h0, 8'h00, 36'hE73100000);
    op = 3'b001; data_in = 4'hF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;

    issue(3'b010, 3'd7, 1'b1, 4'h0, 7, 2'b01, 4'h0, 8'b11111110, 36'h137FFFFFF); // SHL 7 saturates
    issue(3'b001, 3'd0, 1'b0, 4'h8, 1, 2'b11, 4'h8, 8'h00, 36'hF80000000);
    issue(3'b100, 3'd7, 1'b0, 4'h0, 7, 2'b01, 4'h0, 8'b10001000, 36'h812481240); // ROL 7 wraps
    issue(3'b001, 3'd0, 1'b0, 4'h8, 1, 2'b11, 4'h8, 8'h00, 36'h480000000);

    // ROL 5 on 1000, reset asserted after two steps
    issue(3'b100, 3'd5, 1'b0, 4'h0, 5, 2'b01, 4'h0, 8'b10001000, 36'h812481000);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_sel", int'(sel), 0);
    chk("midreset_ready", int'(ready), 1);
    chk("midreset_done", int'(done), 0);
    chk("midreset_ser", int'({ser_lsb, ser_msb}), 0);
    chk("midreset_load_val", int'(load_val), 0);
    repeat (2) @(posedge clk);
    #1 chk("midreset_hold", int'(q), 2);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("postreset_hold", int'(q), 2);

    issue(3'b110, 3'd0, 1'b0, 4'hF, 1, 2'b11, 4'h0, 8'h00, 36'h200000000); // CLEAR

    for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("final_datapath", int'(q), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
